cdiv_arbiter: RTL

Round-robin arbiter that shares one complex_div instance among NUM_REQ requesters (e.g. several triangular-inverse engines or row-normalisation units). Each request is tagged with its requester index. Tags are held in an in-order tag FIFO so that each divider result returns to the requester that issued it. The block sits between the requesters and the divider's operand/result handshake ports. It also forwards flush and reports busy.

---
 rtl/cdiv_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cdiv_arbiter.sv
// Round-robin arbiter sharing one complex divider among NUM_REQ requesters.
// Issuer tags are queued in order so every quotient returns to the requester that asked for it.
module cdiv_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_OUTST = 8,
  parameter int unsigned FLEN      = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0][4*FLEN-1:0] req_operands_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [2*FLEN-1:0]              rsp_result_o,
  output logic [4:0]                     rsp_status_o,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output logic [4*FLEN-1:0]              div_operands_o,
  output logic                           div_in_valid_o,
  input  logic                           div_in_ready_i,
  input  logic [2*FLEN-1:0]              div_result_i,
  input  logic [4:0]                     div_status_i,
  input  logic                           div_out_valid_i,
  output logic                           div_out_ready_o,
  input  logic                           div_busy_i,
  input  logic                           flush_i,
  output logic                           div_flush_o,
  output logic                           busy_o,
  output logic                           err_o
);
  localparam int unsigned IDXW = $clog2(NUM_REQ);
  localparam int unsigned PTRW = $clog2(MAX_OUTST);
  localparam int unsigned CNTW = PTRW + 1;
  localparam logic [IDXW:0]   NREQ  = (IDXW+1)'(NUM_REQ);
  localparam logic [IDXW-1:0] LAST  = IDXW'(NUM_REQ - 1);
  localparam logic [CNTW-1:0] DEPTH = CNTW'(MAX_OUTST);

  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] tag_mem_q [MAX_OUTST];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q;

  logic [IDXW-1:0] gnt_idx, sel_idx, head_tag;
  logic [IDXW:0]   cand;
  logic            fifo_full, fifo_empty, can_issue, push, pop, stray;

  // Scan from the farthest offset down so the nearest valid requester after rr_ptr wins.
  always_comb begin
    gnt_idx = rr_ptr_q;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (req_valid_i[cand[IDXW-1:0]]) gnt_idx = cand[IDXW-1:0];
    end
  end

  assign fifo_full      = (cnt_q == DEPTH);
  assign fifo_empty     = (cnt_q == '0);
  assign can_issue      = rst_ni && (|req_valid_i) && !fifo_full && !flush_i;
  assign sel_idx        = can_issue ? gnt_idx : rr_ptr_q;
  assign div_operands_o = req_operands_i[sel_idx];
  assign div_in_valid_o = can_issue;
  assign push           = can_issue && div_in_ready_i;

  always_comb begin
    req_ready_o          = '0;
    req_ready_o[gnt_idx] = push;
  end

  assign head_tag        = tag_mem_q[rd_ptr_q];
  assign div_out_ready_o = fifo_empty ? 1'b1 : rsp_ready_i[head_tag];
  assign pop             = div_out_valid_i && div_out_ready_o && !fifo_empty;
  assign stray           = div_out_valid_i && fifo_empty;

  always_comb begin
    rsp_valid_o           = '0;
    rsp_valid_o[head_tag] = rst_ni && div_out_valid_i && !fifo_empty && !flush_i;
  end

  assign rsp_result_o = div_result_i;
  assign rsp_status_o = div_status_i;
  assign div_flush_o  = flush_i;
  assign busy_o       = rst_ni && (!fifo_empty || div_busy_i);
  assign err_o        = err_q;

  assign rr_ptr_d = push ? ((gnt_idx == LAST) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;

  always_comb begin
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) tag_mem_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (stray) err_q <= 1'b1;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) begin
          tag_mem_q[wr_ptr_q] <= gnt_idx;
          wr_ptr_q            <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        cnt_q <= cnt_d;
      end
    end
  end

endmodule
